// File: rtl/fpa_ctrl_pkg.sv
// Shared definitions for the floating-point adder front-end arbiter:
// FSM encoding, operand sign position and hold-counter width.
package fpa_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } fpa_state_e;

  localparam int SIGN_BIT = 31;
  localparam int CNT_W    = 4;

  // Subtraction is folded into the adder by flipping the sign of operand b.
  function automatic logic [31:0] apply_sub(input logic [31:0] v, input logic sub);
    logic [31:0] r;
    r           = v;
    r[SIGN_BIT] = v[SIGN_BIT] ^ sub;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to ptr_i.
module rr_arbiter_2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic       grant_o,
  output logic       grant_valid_o
);

  always_comb begin
    grant_valid_o = |valid_i;
    grant_o       = 1'b0;
    if (valid_i == 2'b11) begin
      grant_o = ptr_i;
    end else begin
      grant_o = valid_i[1];
    end
  end

endmodule

// File: rtl/fpa_arbiter.sv
// Shares one external combinational floatingPointAdder between two requesters,
// holding operands for HOLD_CYCLES settle cycles and returning the sum to the owner.
module fpa_arbiter
  import fpa_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req1_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_b,
  input  logic        req0_sub,
  input  logic        req1_sub,
  output logic        resp0_valid,
  output logic        resp1_valid,
  input  logic        resp0_ready,
  input  logic        resp1_ready,
  output logic [31:0] resp_sum,
  output logic [31:0] fpa_n1,
  output logic [31:0] fpa_n2,
  input  logic [31:0] fpa_sum,
  output logic        busy,
  output logic [1:0]  dbg_state_o,
  output logic        dbg_ptr_o
);

  // Handshake: a request transfers on the rising edge where valid && ready;
  // requesters hold valid and operands stable until then. A response transfers
  // on the edge where resp<owner>_valid && resp<owner>_ready; until then the
  // block keeps valid high and resp_sum unchanged.

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  fpa_state_e       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      n1_q, n1_d;
  logic [31:0]      n2_q, n2_d;
  logic [31:0]      sum_q, sum_d;

  logic        grant;
  logic        grant_valid;
  logic        in_idle;
  logic        accept;
  logic        owner_ready;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_sub;

  rr_arbiter_2 u_rr (
    .valid_i       ({req1_valid, req0_valid}),
    .ptr_i         (ptr_q),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  assign in_idle     = (state_q == IDLE);
  assign accept      = in_idle && grant_valid;
  assign req0_ready  = in_idle && req0_valid && (grant == 1'b0);
  assign req1_ready  = in_idle && req1_valid && (grant == 1'b1);
  assign owner_ready = owner_q ? resp1_ready : resp0_ready;

  assign sel_a   = grant ? req1_a   : req0_a;
  assign sel_b   = grant ? req1_b   : req0_b;
  assign sel_sub = grant ? req1_sub : req0_sub;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ptr_d   = ~grant;
          owner_d = grant;
          n1_d    = sel_a;
          n2_d    = apply_sub(sel_b, sel_sub);
          cnt_d   = HOLD_LOAD;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == '0) begin
          sum_d   = fpa_sum;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        // Only the owner's ready can retire the response.
        if (owner_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      n1_q    <= '0;
      n2_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      sum_q   <= sum_d;
    end
  end

  assign resp0_valid = (state_q == RESP) && !owner_q;
  assign resp1_valid = (state_q == RESP) &&  owner_q;
  assign busy        = !in_idle;
  assign resp_sum    = sum_q;
  assign fpa_n1      = n1_q;
  assign fpa_n2      = n2_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

  a_single_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready));

  a_legal_state: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE) || (state_q == ISSUE) || (state_q == RESP));

  a_operands_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |=> ($stable(n1_q) && $stable(n2_q)));

endmodule

// File: tb/tb_fpa_arbiter.sv
// Directed bench for fpa_arbiter: three instances (HOLD_CYCLES 1, 3, 4) share one
// clock, each driven by a table-based stand-in for the external adder.
module tb_fpa_arbiter;

  logic clk;
  logic [2:0] rst_n;
  logic [2:0] req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0] req0_sub, req1_sub;
  logic [2:0] resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [2:0] busy, dbg_ptr;
  logic [2:0][1:0]  dbg_state;
  logic [2:0][31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0][31:0] resp_sum, fpa_n1, fpa_n2, fpa_sum;

  int errors;
  int checks;
  logic [0:0] exp_q[$];

  // Single-precision sums for the operand pairs the bench uses; anything else is qNaN.
  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h0000_0000, 32'h0000_0000}: return 32'h0000_0000;
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'h4000_0000, 32'h3F80_0000}: return 32'h4040_0000;
      {32'h4040_0000, 32'hBF80_0000}: return 32'h4000_0000;
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
      {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
      default:                        return 32'h7FC0_0000;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int H = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    fpa_arbiter #(.HOLD_CYCLES(H)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n[g]),
      .req0_valid  (req0_valid[g]),
      .req1_valid  (req1_valid[g]),
      .req0_ready  (req0_ready[g]),
      .req1_ready  (req1_ready[g]),
      .req0_a      (req0_a[g]),
      .req1_a      (req1_a[g]),
      .req0_b      (req0_b[g]),
      .req1_b      (req1_b[g]),
      .req0_sub    (req0_sub[g]),
      .req1_sub    (req1_sub[g]),
      .resp0_valid (resp0_valid[g]),
      .resp1_valid (resp1_valid[g]),
      .resp0_ready (resp0_ready[g]),
      .resp1_ready (resp1_ready[g]),
      .resp_sum    (resp_sum[g]),
      .fpa_n1      (fpa_n1[g]),
      .fpa_n2      (fpa_n2[g]),
      .fpa_sum     (fpa_sum[g]),
      .busy        (busy[g]),
      .dbg_state_o (dbg_state[g]),
      .dbg_ptr_o   (dbg_ptr[g])
    );
    assign fpa_sum[g] = fp_model(fpa_n1[g], fpa_n2[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = '0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({req0_ready[k], req1_ready[k], resp0_valid[k], resp1_valid[k], busy[k], dbg_ptr[k]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_ctl[%0d]: got %b want 000000", k,
                 {req0_ready[k], req1_ready[k], resp0_valid[k], resp1_valid[k], busy[k], dbg_ptr[k]});
      end
      checks++;
      if ({fpa_n1[k], fpa_n2[k], resp_sum[k]} !== 96'b0) begin
        errors++;
        $display("FAIL reset_data[%0d]: got n1=%h n2=%h sum=%h want 0", k, fpa_n1[k], fpa_n2[k], resp_sum[k]);
      end
      checks++;
      if (dbg_state[k] !== 2'b00) begin
        errors++;
        $display("FAIL reset_state[%0d]: got %b want 00", k, dbg_state[k]);
      end
    end
    tick();
    @(negedge clk);
    rst_n = '1;
    tick();
  endtask

  task automatic test_add();
    req0_a[0] = 32'h3F80_0000; req0_b[0] = 32'h4000_0000; req0_sub[0] = 1'b0;
    req0_valid[0] = 1'b1;
    #1;
    checks++;
    if ({req0_ready[0], req1_ready[0]} !== 2'b10) begin
      errors++; $display("FAIL add_ready: got %b want 10", {req0_ready[0], req1_ready[0]});
    end
    tick();
    req0_valid[0] = 1'b0;
    checks++;
    if ({busy[0], dbg_state[0], resp0_valid[0]} !== 4'b1010) begin
      errors++; $display("FAIL add_issue: got %b want 1010", {busy[0], dbg_state[0], resp0_valid[0]});
    end
    checks++;
    if ({fpa_n1[0], fpa_n2[0]} !== {32'h3F80_0000, 32'h4000_0000}) begin
      errors++; $display("FAIL add_operands: got %h %h want 3f800000 40000000", fpa_n1[0], fpa_n2[0]);
    end
    tick();
    checks++;
    if ({resp0_valid[0], resp1_valid[0]} !== 2'b10) begin
      errors++; $display("FAIL add_resp_valid: got %b want 10", {resp0_valid[0], resp1_valid[0]});
    end
    checks++;
    if (resp_sum[0] !== 32'h4040_0000) begin
      errors++; $display("FAIL add_sum: got %h want 40400000", resp_sum[0]);
    end
    resp0_ready[0] = 1'b1;
    tick();
    resp0_ready[0] = 1'b0;
    checks++;
    if ({busy[0], resp0_valid[0]} !== 2'b00) begin
      errors++; $display("FAIL add_retire: got %b want 00", {busy[0], resp0_valid[0]});
    end
  endtask

  task automatic test_sub();
    req1_a[0] = 32'h4040_0000; req1_b[0] = 32'h3F80_0000; req1_sub[0] = 1'b1;
    req1_valid[0] = 1'b1;
    #1;
    checks++;
    if (req1_ready[0] !== 1'b1) begin
      errors++; $display("FAIL sub_ready: got %b want 1", req1_ready[0]);
    end
    tick();
    req1_valid[0] = 1'b0;
    checks++;
    if ({fpa_n1[0], fpa_n2[0]} !== {32'h4040_0000, 32'hBF80_0000}) begin
      errors++; $display("FAIL sub_operands: got %h %h want 40400000 bf800000", fpa_n1[0], fpa_n2[0]);
    end
    tick();
    checks++;
    if ({resp1_valid[0], resp0_valid[0]} !== 2'b10) begin
      errors++; $display("FAIL sub_resp_valid: got %b want 10", {resp1_valid[0], resp0_valid[0]});
    end
    checks++;
    if (resp_sum[0] !== 32'h4000_0000) begin
      errors++; $display("FAIL sub_sum: got %h want 40000000", resp_sum[0]);
    end
    resp0_ready[0] = 1'b1;
    tick();
    resp0_ready[0] = 1'b0;
    checks++;
    if ({resp1_valid[0], busy[0]} !== 2'b11) begin
      errors++; $display("FAIL sub_nonowner_ready: got %b want 11", {resp1_valid[0], busy[0]});
    end
    resp1_ready[0] = 1'b1;
    tick();
    resp1_ready[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++; $display("FAIL sub_retire: got %b want 0", busy[0]);
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic [0:0] want;
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    req0_a[0] = 32'h3F80_0000; req0_b[0] = 32'h3F80_0000; req0_sub[0] = 1'b0;
    req1_a[0] = 32'h4000_0000; req1_b[0] = 32'h4000_0000; req1_sub[0] = 1'b0;
    req0_valid[0] = 1'b1; req1_valid[0] = 1'b1;
    resp0_ready[0] = 1'b1; resp1_ready[0] = 1'b1;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    n = 0;
    #1;
    for (int c = 0; c < 30 && n < 4; c++) begin
      if (req0_ready[0] && req1_ready[0]) begin
        checks++; errors++; $display("FAIL rr_double_grant: got 11 want one-hot");
      end else if (req0_ready[0] || req1_ready[0]) begin
        want = exp_q.pop_front();
        checks++;
        if (req1_ready[0] !== want) begin
          errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", n, req1_ready[0], want);
        end
        n++;
      end
      if (resp0_valid[0]) begin
        checks++;
        if (resp_sum[0] !== 32'h4000_0000) begin
          errors++; $display("FAIL rr_sum0: got %h want 40000000", resp_sum[0]);
        end
      end
      if (resp1_valid[0]) begin
        checks++;
        if (resp_sum[0] !== 32'h4080_0000) begin
          errors++; $display("FAIL rr_sum1: got %h want 40800000", resp_sum[0]);
        end
      end
      tick();
    end
    req0_valid[0] = 1'b0; req1_valid[0] = 1'b0;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL rr_timeout: got %0d grants want 4", n);
    end
    repeat (3) tick();
    resp0_ready[0] = 1'b0; resp1_ready[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++; $display("FAIL rr_drain: got busy %b want 0", busy[0]);
    end
  endtask

  task automatic test_stall();
    req0_a[0] = 32'h3F80_0000; req0_b[0] = 32'h4000_0000; req0_sub[0] = 1'b0;
    req0_valid[0] = 1'b1;
    tick();
    req0_valid[0] = 1'b0;
    tick();
    req1_a[0] = 32'h3F80_0000; req1_b[0] = 32'h3F80_0000; req1_sub[0] = 1'b0;
    req1_valid[0] = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({resp0_valid[0], busy[0], req0_ready[0], req1_ready[0]} !== 4'b1100) begin
        errors++; $display("FAIL stall_ctl[%0d]: got %b want 1100", c,
                           {resp0_valid[0], busy[0], req0_ready[0], req1_ready[0]});
      end
      checks++;
      if ({resp_sum[0], fpa_n1[0]} !== {32'h4040_0000, 32'h3F80_0000}) begin
        errors++; $display("FAIL stall_hold[%0d]: got sum=%h n1=%h want 40400000 3f800000", c, resp_sum[0], fpa_n1[0]);
      end
      tick();
    end
    resp0_ready[0] = 1'b1;
    tick();
    resp0_ready[0] = 1'b0;
    checks++;
    if (req1_ready[0] !== 1'b1) begin
      errors++; $display("FAIL stall_pending_req: got %b want 1", req1_ready[0]);
    end
    tick();
    req1_valid[0] = 1'b0;
    tick();
    checks++;
    if ({resp1_valid[0], resp_sum[0]} !== {1'b1, 32'h4000_0000}) begin
      errors++; $display("FAIL stall_resp1: got %b %h want 1 40000000", resp1_valid[0], resp_sum[0]);
    end
    resp1_ready[0] = 1'b1;
    tick();
    resp1_ready[0] = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    req0_a[1] = 32'h3F80_0000; req0_b[1] = 32'h4000_0000; req0_sub[1] = 1'b0;
    req0_valid[1] = 1'b1; resp0_ready[1] = 1'b1;
    tick();
    req0_valid[1] = 1'b0;
    tick();
    tick();
    checks++;
    if (resp0_valid[1] !== 1'b0) begin
      errors++; $display("FAIL h3_early_resp: got %b want 0", resp0_valid[1]);
    end
    tick();
    checks++;
    if ({resp0_valid[1], resp_sum[1]} !== {1'b1, 32'h4040_0000}) begin
      errors++; $display("FAIL h3_resp: got %b %h want 1 40400000", resp0_valid[1], resp_sum[1]);
    end
    tick();
    resp0_ready[1] = 1'b0;
    req0_valid[1] = 1'b1;
    tick();
    req0_valid[1] = 1'b0;
    tick();
    checks++;
    if ({dbg_state[1], dbg_ptr[1]} !== 3'b011) begin
      errors++; $display("FAIL h3_pre_reset: got %b want 011", {dbg_state[1], dbg_ptr[1]});
    end
    rst_n[1] = 1'b0;
    #1;
    checks++;
    if ({req0_ready[1], req1_ready[1], resp0_valid[1], resp1_valid[1], busy[1], dbg_ptr[1], dbg_state[1]} !== 7'b0) begin
      errors++; $display("FAIL h3_reset_ctl: got %b want 0000000",
                         {req0_ready[1], req1_ready[1], resp0_valid[1], resp1_valid[1], busy[1], dbg_ptr[1], dbg_state[1]});
    end
    checks++;
    if ({fpa_n1[1], fpa_n2[1], resp_sum[1]} !== 96'b0) begin
      errors++; $display("FAIL h3_reset_data: got %h %h %h want 0", fpa_n1[1], fpa_n2[1], resp_sum[1]);
    end
    tick();
    rst_n[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({resp0_valid[1], resp1_valid[1], busy[1]} !== 3'b000) begin
        errors++; $display("FAIL h3_no_resp[%0d]: got %b want 000", c, {resp0_valid[1], resp1_valid[1], busy[1]});
      end
      tick();
    end
    req1_a[1] = 32'h4000_0000; req1_b[1] = 32'h4000_0000; req1_sub[1] = 1'b0;
    req0_valid[1] = 1'b1; req1_valid[1] = 1'b1;
    #1;
    checks++;
    if ({req0_ready[1], req1_ready[1]} !== 2'b10) begin
      errors++; $display("FAIL h3_post_reset_grant: got %b want 10", {req0_ready[1], req1_ready[1]});
    end
    req0_valid[1] = 1'b0; req1_valid[1] = 1'b0;
    rst_n[1] = 1'b0;
    tick();
    rst_n[1] = 1'b1;
  endtask

  task automatic test_hold4();
    int acc_q[$];
    int rs_q[$];
    logic prev_v;
    logic v;
    req0_a[2] = 32'h3F80_0000; req0_b[2] = 32'h4000_0000; req0_sub[2] = 1'b0;
    req1_a[2] = 32'h4040_0000; req1_b[2] = 32'h3F80_0000; req1_sub[2] = 1'b1;
    req0_valid[2] = 1'b1; req1_valid[2] = 1'b1;
    resp0_ready[2] = 1'b1; resp1_ready[2] = 1'b1;
    prev_v = 1'b0;
    #1;
    for (int e = 0; e < 25; e++) begin
      if (req0_ready[2] || req1_ready[2]) acc_q.push_back(e + 1);
      v = resp0_valid[2] || resp1_valid[2];
      if (v && !prev_v) rs_q.push_back(e);
      prev_v = v;
      tick();
    end
    req0_valid[2] = 1'b0; req1_valid[2] = 1'b0;
    checks++;
    if (acc_q.size() < 3 || rs_q.size() < 2) begin
      errors++; $display("FAIL h4_timeout: got %0d accepts %0d resps want >=3 >=2", acc_q.size(), rs_q.size());
    end else begin
      checks++;
      if (rs_q[0] - acc_q[0] != 4) begin
        errors++; $display("FAIL h4_latency0: got %0d want 4", rs_q[0] - acc_q[0]);
      end
      checks++;
      if (rs_q[1] - acc_q[1] != 4) begin
        errors++; $display("FAIL h4_latency1: got %0d want 4", rs_q[1] - acc_q[1]);
      end
      checks++;
      if (acc_q[1] - acc_q[0] != 6) begin
        errors++; $display("FAIL h4_spacing0: got %0d want 6", acc_q[1] - acc_q[0]);
      end
      checks++;
      if (acc_q[2] - acc_q[1] != 6) begin
        errors++; $display("FAIL h4_spacing1: got %0d want 6", acc_q[2] - acc_q[1]);
      end
    end
    repeat (8) tick();
    checks++;
    if (busy[2] !== 1'b0) begin
      errors++; $display("FAIL h4_drain: got busy %b want 0", busy[2]);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    req0_valid = '0; req1_valid = '0; req0_sub = '0; req1_sub = '0;
    resp0_ready = '0; resp1_ready = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    test_reset();
    test_add();
    test_sub();
    test_round_robin();
    test_stall();
    test_reset_mid_issue();
    test_hold4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
